// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             ex_mc_start;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_flush;
    logic             mc_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
               ex_mem_read, ex_branch_taken, ex_mc_start,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_flush, mc_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd,
               ex_mem_read, ex_branch_taken, ex_mc_start,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_flush, mc_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and multi-cycle EX holds, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int CW = $clog2(MC_LAT);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic [1:0][4:0] id_rs;
    logic [1:0]      id_used;
    logic [1:0]      src_hit;
    logic            load_use;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mc_busy;

    assign id_rs   = {hz.id_rs2, hz.id_rs1};
    assign id_used = {hz.id_rs2_used, hz.id_rs1_used};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = id_used[gi] && (id_rs[gi] == hz.ex_rd);
    end

    // x0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (|src_hit);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_busy     = 1'b0;
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_RUN;
            mc_cnt_d    = '0;
        end else if (state_q == ST_MC_WAIT) begin
            mc_busy = 1'b1;
            if (mc_cnt_q != '0) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                mc_cnt_d    = mc_cnt_q - CW'(1);
            end else begin
                state_d = ST_RUN;
            end
        end else if (hz.ex_branch_taken) begin
            // PC keeps moving to take the redirect; the two wrong-path slots are squashed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hz.ex_mc_start) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = ST_MC_WAIT;
            mc_cnt_d    = CW'(MC_LAT - 2);
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            mc_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            mc_cnt_q       <= mc_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.idex_flush   = idex_flush;
    assign hz.exmem_flush  = exmem_flush;
    assign hz.mc_busy      = mc_busy;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic against a cycle-index reference model; a 4-bit-counter copy checks saturation.
module tb_pipe_hazard_ctrl;
    localparam int MC_LAT = 4;

    // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, mc_busy}
    localparam logic [6:0] C_DEF  = 7'b1101000;
    localparam logic [6:0] C_RST  = 7'b0010110;
    localparam logic [6:0] C_BR   = 7'b1111100;
    localparam logic [6:0] C_MC   = 7'b0000010;
    localparam logic [6:0] C_LU   = 7'b0001100;
    localparam logic [6:0] C_BUSY = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_if #(.CNT_W(32)) bus ();
    pipe_hazard_if #(.CNT_W(4))  bus4 ();

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .hz(bus));
    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .hz(bus4));

    assign bus4.id_rs1          = bus.id_rs1;
    assign bus4.id_rs2          = bus.id_rs2;
    assign bus4.id_rs1_used     = bus.id_rs1_used;
    assign bus4.id_rs2_used     = bus.id_rs2_used;
    assign bus4.ex_rd           = bus.ex_rd;
    assign bus4.ex_mem_read     = bus.ex_mem_read;
    assign bus4.ex_branch_taken = bus.ex_branch_taken;
    assign bus4.ex_mc_start     = bus.ex_mc_start;

    always #5 clk = ~clk;

    // Model: m_phase is the 1-based cycle index inside a multi-cycle op (0 = none).
    int          m_phase = 0, m_phase_n;
    longint      m_stall = 0, m_stall_n;
    logic [6:0]  exp_ctl;
    longint      exp_cnt, exp_cnt4;

    function automatic logic [6:0] obs_ctl();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                bus.idex_flush, bus.exmem_flush, bus.mc_busy};
    endfunction

    task automatic model_eval();
        bit lu;
        lu = bus.ex_mem_read && (bus.ex_rd != 0) &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        exp_ctl   = C_DEF;
        exp_cnt   = m_stall;
        exp_cnt4  = (m_stall > 15) ? 15 : m_stall;
        m_phase_n = m_phase;
        m_stall_n = m_stall;
        if (rst) begin
            exp_ctl   = C_RST;
            m_phase_n = 0;
            m_stall_n = 0;
        end else begin
            if (m_phase != 0) begin
                exp_ctl   = ((m_phase < MC_LAT) ? C_MC : C_DEF) | C_BUSY;
                m_phase_n = (m_phase < MC_LAT) ? m_phase + 1 : 0;
            end else if (bus.ex_branch_taken) begin
                exp_ctl = C_BR;
            end else if (bus.ex_mc_start) begin
                exp_ctl   = C_MC;
                m_phase_n = 2;
            end else if (lu) begin
                exp_ctl = C_LU;
            end
            if (exp_ctl[6] == 1'b0) m_stall_n = m_stall + 1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        m_phase = m_phase_n;
        m_stall = m_stall_n;
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic mr,
                          input logic br, input logic mc);
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rs1_used = u1; bus.id_rs2_used = u2;
        bus.ex_rd = rd; bus.ex_mem_read = mr; bus.ex_branch_taken = br; bus.ex_mc_start = mc;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk); model_eval(); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(5'd3, 5'd3, 1, 1, 5'd3, 1, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_eval();
            checks++;
            if (obs_ctl() !== C_RST) begin
                errors++; $display("FAIL reset_ctl cyc%0d: got %b want %b", i, obs_ctl(), C_RST);
            end
            advance();
        end
        checks++;
        if (bus.stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", bus.stall_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5'd5, 5'd9, 1, 0, 5'd5, 1, 0, 0);
        @(negedge clk); model_eval();
        checks++;
        if (obs_ctl() !== C_LU || exp_ctl !== C_LU) begin
            errors++; $display("FAIL load_use_stall: got %b model %b want %b", obs_ctl(), exp_ctl, C_LU);
        end
        advance();
        set_in(5'd1, 5'd2, 1, 1, 5'd5, 0, 0, 0);
        @(negedge clk); model_eval();
        checks++;
        if (obs_ctl() !== C_DEF || bus.stall_cycles !== 32'd1) begin
            errors++; $display("FAIL load_use_after: got %b cnt %0d want %b cnt 1",
                               obs_ctl(), bus.stall_cycles, C_DEF);
        end
        advance();
    endtask

    task automatic test_no_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_in(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0);
                1: set_in(5'd5, 5'd7, 0, 1, 5'd5, 1, 0, 0);
                default: set_in(5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0);
            endcase
            @(negedge clk); model_eval();
            checks++;
            if (obs_ctl() !== C_DEF || bus.stall_cycles !== 32'd0) begin
                errors++; $display("FAIL no_stall case%0d: got %b cnt %0d want %b cnt 0",
                                   i, obs_ctl(), bus.stall_cycles, C_DEF);
            end
            advance();
        end
    endtask

    task automatic test_multicycle();
        logic [6:0] want [5];
        want = '{C_MC, C_MC | C_BUSY, C_MC | C_BUSY, C_DEF | C_BUSY, C_DEF};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, (i == 0));
            @(negedge clk); model_eval();
            checks++;
            if (obs_ctl() !== want[i] || exp_ctl !== want[i]) begin
                errors++; $display("FAIL mc_seq cyc%0d: got %b model %b want %b",
                                   i + 1, obs_ctl(), exp_ctl, want[i]);
            end
            advance();
        end
        checks++;
        if (bus.stall_cycles !== 32'd3) begin
            errors++; $display("FAIL mc_cnt: got %0d want 3", bus.stall_cycles);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_in(5'd6, 5'd6, 1, 1, 5'd6, 1, 1, 1);
        @(negedge clk); model_eval();
        checks++;
        if (obs_ctl() !== C_BR) begin
            errors++; $display("FAIL branch_ctl: got %b want %b", obs_ctl(), C_BR);
        end
        advance();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk); model_eval();
        checks++;
        if (obs_ctl() !== C_DEF || bus.stall_cycles !== 32'd0) begin
            errors++; $display("FAIL branch_after: got %b cnt %0d want %b cnt 0",
                               obs_ctl(), bus.stall_cycles, C_DEF);
        end
        advance();
    endtask

    task automatic test_reset_mid_mc();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, (i == 0));
            rst = (i == 2);
            @(negedge clk); model_eval();
            checks++;
            if (obs_ctl() !== exp_ctl || bus.stall_cycles !== 32'(exp_cnt)) begin
                errors++; $display("FAIL mc_reset cyc%0d: got %b cnt %0d want %b cnt %0d",
                                   i, obs_ctl(), bus.stall_cycles, exp_ctl, exp_cnt);
            end
            advance();
        end
        checks++;
        if (obs_ctl() !== C_DEF || bus.stall_cycles !== 32'd0) begin
            errors++; $display("FAIL mc_reset_residue: got %b cnt %0d want %b cnt 0",
                               obs_ctl(), bus.stall_cycles, C_DEF);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(5'd0, 5'd8, 0, 1, 5'd8, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); model_eval();
            checks++;
            if (bus4.stall_cycles !== 4'(exp_cnt4)) begin
                errors++; $display("FAIL sat_track cyc%0d: got %0d want %0d", i, bus4.stall_cycles, exp_cnt4);
            end
            advance();
        end
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        @(negedge clk); model_eval();
        checks++;
        if (bus4.stall_cycles !== 4'd15 || bus.stall_cycles !== 32'd20) begin
            errors++; $display("FAIL sat_final: got %0d/%0d want 15/20", bus4.stall_cycles, bus.stall_cycles);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk); model_eval();
            checks++;
            if (obs_ctl() !== exp_ctl) begin
                errors++; $display("FAIL rand_ctl cyc%0d: got %b want %b", i, obs_ctl(), exp_ctl);
            end
            checks++;
            if (bus.stall_cycles !== 32'(exp_cnt) || bus4.stall_cycles !== 4'(exp_cnt4)) begin
                errors++; $display("FAIL rand_cnt cyc%0d: got %0d/%0d want %0d/%0d", i,
                                   bus.stall_cycles, bus4.stall_cycles, exp_cnt, exp_cnt4);
            end
            advance();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_multicycle();
        test_branch_priority();
        test_reset_mid_mc();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
